// File: rtl/mem_access_stage_if.sv
// Pipeline-side and data-memory-bus signals of the MEM-stage load/store unit.
// master = the stage itself, slave = the pipeline/memory environment around it.
interface mem_access_stage_if;
    logic        valid;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  memSize;
    logic        memSigned;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [31:0] ramR;
    logic        stall;
    logic        misalign;
    logic        busFault;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memAck;

    modport master (
        input  valid, memRead, memWrite, memSize, memSigned, address, storeData,
        input  memRData, memAck,
        output ramR, stall, misalign, busFault,
        output memReq, memWe, memAddr, memBe, memWData
    );

    modport slave (
        output valid, memRead, memWrite, memSize, memSigned, address, storeData,
        output memRData, memAck,
        input  ramR, stall, misalign, busFault,
        input  memReq, memWe, memAddr, memBe, memWData
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: one req/ack bus transaction per load/store, aligned+extended load result.
// Latency >= 3 cycles (IDLE, BUSY.., DONE); stalls the pipeline from start until DONE, aborts after TIMEOUT_CYCLES.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clock,
    input  logic               resetN,
    mem_access_stage_if.master bus
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        load_q, load_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;

    logic        is_acc;
    logic        aligned;
    logic        start;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    always_comb begin
        is_acc = bus.valid & (bus.memRead | bus.memWrite);
        case (bus.memSize)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~bus.address[0];
            2'b10:   aligned = (bus.address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        start = is_acc & aligned;

        case (bus.memSize)
            2'b00: begin
                st_be    = 4'b0001 << bus.address[1:0];
                st_wdata = {4{bus.storeData[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {bus.address[1], 1'b0};
                st_wdata = {2{bus.storeData[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = bus.storeData;
            end
        endcase
    end

    // Load alignment uses the offset/size latched in IDLE, not the live inputs.
    always_comb begin
        rd_byte = bus.memRData[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? bus.memRData[31:16] : bus.memRData[15:0];
        case (size_q)
            2'b00:   rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: rd_ext = bus.memRData;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        off_d   = off_q;
        data_d  = data_q;
        fault_d = fault_q;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                fault_d = 1'b0;
                if (start) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = ~bus.memRead;
                    addr_d  = {bus.address[31:2], 2'b00};
                    be_d    = bus.memRead ? 4'b1111 : st_be;
                    wdata_d = bus.memRead ? 32'h0 : st_wdata;
                    load_d  = bus.memRead;
                    size_d  = bus.memSize;
                    sgn_d   = bus.memSigned;
                    off_d   = bus.address[1:0];
                    data_d  = 32'h0;
                end
            end
            BUSY: begin
                if (bus.memAck) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    data_d  = load_q ? rd_ext : 32'h0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    data_d  = 32'h0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                fault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            load_q  <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            off_q   <= 2'b00;
            data_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            off_q   <= off_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    // The IDLE-cycle stall/misalign terms are combinational, so gate them with reset too.
    assign bus.stall    = resetN & (((state_q == IDLE) & start) | (state_q == BUSY));
    assign bus.misalign = resetN & (state_q == IDLE) & is_acc & ~aligned;
    assign bus.busFault = (state_q == DONE) & fault_q;
    assign bus.ramR     = ((state_q == DONE) & load_q) ? data_q : 32'h0;
    assign bus.memReq   = req_q;
    assign bus.memWe    = we_q;
    assign bus.memAddr  = addr_q;
    assign bus.memBe    = be_q;
    assign bus.memWData = wdata_q;
endmodule
